// File: rtl/regfile_scan_reader.sv
// rtl/regfile_scan_reader.sv - register file scan engine streaming register values two reads at a time
//
// Ports:
//   clk, rst            clock and synchronous active-low reset
//   start               one-cycle scan request, accepted only when idle
//   first_addr          first register of the range, sampled with start
//   last_addr           last register of the range (inclusive), sampled with start
//   regAddress1/2       read port addresses to the register file
//   readData1/2         combinational read data for regAddress1/2
//   readR15             dedicated R15 output of the register file
//   out_valid/ready     stream handshake
//   out_data/addr/last  beat payload: register value, its index, final-beat flag
//   r15_snap            readR15 captured on the accepted start
//   busy, done          status: not idle / one-cycle completion pulse

module regfile_scan_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] regAddress1,
    output logic [ADDR_WIDTH-1:0] regAddress2,
    input  logic [DATA_WIDTH-1:0] readData1,
    input  logic [DATA_WIDTH-1:0] readData2,
    input  logic [DATA_WIDTH-1:0] readR15,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] r15_snap,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        SEND0 = 3'd2,
        SEND1 = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] THREE = ADDR_WIDTH'(3);

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] cur, last_reg;
    logic [DATA_WIDTH-1:0] buf0, buf1;
    logic [ADDR_WIDTH-1:0] cur_p1;
    logic                  handshake;

    assign cur_p1    = cur + ONE;
    assign handshake = out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        next_state = state;
        out_valid  = 1'b0;
        out_data   = '0;
        out_addr   = '0;
        out_last   = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    next_state = (first_addr <= last_addr) ? READ : DONE;
            end
            READ: next_state = SEND0;
            SEND0: begin
                out_valid = 1'b1;
                out_data  = buf0;
                out_addr  = cur;
                out_last  = (cur == last_reg);
                if (handshake)
                    next_state = (cur == last_reg) ? DONE : SEND1;
            end
            SEND1: begin
                out_valid = 1'b1;
                out_data  = buf1;
                out_addr  = cur_p1;
                out_last  = (cur_p1 == last_reg);
                if (handshake)
                    next_state = (cur_p1 == last_reg) ? DONE : READ;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The address registers are loaded on the edge that enters READ so the
    // register file presents valid data throughout the READ cycle; they keep
    // their value in every other state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cur         <= '0;
            last_reg    <= '0;
            buf0        <= '0;
            buf1        <= '0;
            r15_snap    <= '0;
            regAddress1 <= '0;
            regAddress2 <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur      <= first_addr;
                        last_reg <= last_addr;
                        r15_snap <= readR15;
                        if (first_addr <= last_addr) begin
                            regAddress1 <= first_addr;
                            regAddress2 <= first_addr + ONE;
                        end
                    end
                end
                READ: begin
                    buf0 <= readData1;
                    buf1 <= readData2;
                end
                SEND1: begin
                    // cur+1 < last here, so cur+2 never passes the top register.
                    if (handshake && (cur_p1 != last_reg)) begin
                        cur         <= cur + TWO;
                        regAddress1 <= cur + TWO;
                        regAddress2 <= cur + THREE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scan_reader.sv
// tb/tb_regfile_scan_reader.sv - directed testbench for regfile_scan_reader

module tb_regfile_scan_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  first_addr, last_addr;
    logic [3:0]  regAddress1, regAddress2;
    logic [15:0] readData1, readData2, readR15;
    logic        out_valid, out_ready, out_last, busy, done;
    logic [15:0] out_data, r15_snap;
    logic [3:0]  out_addr;

    logic [15:0] regs [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign readData1 = regs[regAddress1];
    assign readData2 = regs[regAddress2];
    assign readR15   = regs[15];

    regfile_scan_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .regAddress1(regAddress1), .regAddress2(regAddress2),
        .readData1(readData1), .readData2(readData2), .readR15(readR15),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .r15_snap(r15_snap), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_addr"}, out_addr, 0);
        chk({tag, "_last"}, out_last, 0);
    endtask

    // Called right after a falling edge; returns right after a falling edge.
    task automatic run_scan(input logic [3:0] f, input logic [3:0] l,
                            input bit toggle, input int exp_cycles);
        int k;
        bit acc_last;
        bit fin;
        logic [15:0] snap;
        logic [3:0] f_p1;
        snap = regs[15];
        f_p1 = f + 4'd1;
        start = 1'b1; first_addr = f; last_addr = l;
        @(negedge clk);
        start = 1'b0;
        if (f > l) begin
            chk("empty_done", done, 1);
            chk("empty_busy", busy, 1);
            chk("empty_valid", out_valid, 0);
            @(negedge clk);
            chk("empty_done_end", done, 0);
            chk("empty_busy_end", busy, 0);
            chk("empty_snap", r15_snap, snap);
            return;
        end
        chk("read_addr1", regAddress1, f);
        chk("read_addr2", regAddress2, f_p1);
        chk("read_busy", busy, 1);
        chk("read_valid", out_valid, 0);
        k = f; acc_last = 0; fin = 0;
        for (int c = 0; c < 100 && !fin; c++) begin
            @(negedge clk);
            if (c == 0) chk("first_valid", out_valid, 1);
            if (acc_last) begin
                chk("done_after_last", done, 1);
                chk("valid_in_done", out_valid, 0);
                if (exp_cycles > 0) chk("cycle_count", c + 1, exp_cycles);
                fin = 1;
            end else begin
                chk("early_done", done, 0);
                if (out_valid) begin
                    chk("beat_addr", out_addr, k);
                    chk("beat_data", out_data, regs[k]);
                    chk("beat_last", out_last, (k == int'(l)));
                end
                out_ready = toggle ? (c % 2 == 0) : 1'b1;
                if (out_valid && out_ready) begin
                    if (k == int'(l)) acc_last = 1;
                    k++;
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
        chk("beat_count", k, int'(l) + 1);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("snap", r15_snap, snap);
        out_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
        rst = 1'b0; start = 1'b1; first_addr = 4'd3; last_addr = 4'd9; out_ready = 1'b1;

        // reset with active inputs
        @(negedge clk);
        @(negedge clk);
        chk_quiet("rst");
        chk("rst_snap", r15_snap, 0);
        chk("rst_ra1", regAddress1, 0);
        chk("rst_ra2", regAddress2, 0);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        chk_quiet("post_rst");
        chk("post_rst_snap", r15_snap, 0);

        // full scan, 16 beats, 2 beats per 3 cycles
        run_scan(4'd0, 4'd15, 1'b0, 24);
        chk("full_snap", r15_snap, 16'h100F);

        // odd range with alternating backpressure
        regs[11] = 16'h0C3E;
        run_scan(4'd11, 4'd14, 1'b1, 0);

        // single register at the top, port 2 wraps to 0
        regs[15] = 16'hABCD;
        run_scan(4'd15, 4'd15, 1'b0, 2);
        chk("single_snap", r15_snap, 16'hABCD);

        // empty range
        run_scan(4'd5, 4'd2, 1'b0, 0);

        // start ignored in SEND1 under backpressure, then abort via reset
        out_ready = 1'b0;
        start = 1'b1; first_addr = 4'd0; last_addr = 4'd15;
        @(negedge clk);             // READ
        start = 1'b0;
        @(negedge clk);             // SEND0
        chk("ab_s0_addr", out_addr, 0);
        out_ready = 1'b1;
        @(negedge clk);             // SEND1
        chk("ab_s1_addr", out_addr, 1);
        out_ready = 1'b0;
        start = 1'b1; first_addr = 4'd7; last_addr = 4'd9;
        @(negedge clk);
        start = 1'b0;
        chk("ab_hold_valid", out_valid, 1);
        chk("ab_hold_addr", out_addr, 1);
        chk("ab_hold_data", out_data, 16'h1001);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_quiet("abort");
        out_ready = 1'b1;
        @(negedge clk);
        chk("abort_no_done", done, 0);
        chk("abort_no_valid", out_valid, 0);

        // fresh scan after abort
        run_scan(4'd2, 4'd5, 1'b0, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
